// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Consumed by regfile_mp and regfile_scoreboard.
package regfile_pkg;

   localparam int unsigned W_DEF        = 32;
   localparam int unsigned DEPTH_DEF    = 32;
   localparam int unsigned NRD_DEF      = 2;
   localparam int unsigned LINK_REG_DEF = 31;
   localparam int unsigned LINK_OFS_DEF = 4;
   localparam int unsigned AW_DEF       = $clog2(DEPTH_DEF);

   typedef logic [AW_DEF-1:0] reg_idx_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit.
// A set and a clear of the same register in one cycle leaves the bit set.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned NRD   = NRD_DEF,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic [DEPTH-1:0]  clr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    busy
);

   logic [DEPTH-1:0] pend_q, pend_d, set_vec;

   always_comb begin
      set_vec = '0;
      if (set_en) set_vec[set_addr] = 1'b1;
      pend_d    = (pend_q & ~clr) | set_vec;
      // r0 never has a producer, so it can never be busy
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_busy
      assign busy[i] = pend_q[rd_addr[i*AW +: AW]];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, writeback + link write, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes into the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned W        = W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned NRD      = NRD_DEF,
   parameter int unsigned LINK_REG = LINK_REG_DEF,
   parameter int unsigned LINK_OFS = LINK_OFS_DEF,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*W-1:0]  rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [W-1:0]      wr_data,
   input  logic              link_en,
   input  logic [W-1:0]      link_pc,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   output logic [7:0]        collide_cnt
);

   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     link_val;
   logic             collide, wr_commit;
   logic [DEPTH-1:0] clr;
   logic [NRD-1:0]   busy_raw;
   logic [7:0]       cnt_q;

   assign link_val  = link_pc + W'(LINK_OFS);
   // The link port owns LINK_REG; a writeback aimed there in the same cycle is dropped
   assign collide   = wr_en && link_en && (wr_addr == LINK_IDX);
   assign wr_commit = wr_en && (wr_addr != '0) && !collide;

   always_comb begin
      clr = '0;
      if (wr_commit) clr[wr_addr]  = 1'b1;
      if (link_en)   clr[LINK_IDX] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr_commit) mem_q[wr_addr]  <= wr_data;
         if (link_en)   mem_q[LINK_IDX] <= link_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= 8'd0;
      else if (collide) cnt_q <= sat_inc8(cnt_q);
   end

   assign collide_cnt = cnt_q;

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .NRD   (NRD)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (iss_en),
      .set_addr (iss_addr),
      .clr      (clr),
      .rd_addr  (rd_addr),
      .busy     (busy_raw)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic [W-1:0]  stored;
      assign a      = rd_addr[i*AW +: AW];
      assign stored = (a == '0) ? '0 : mem_q[a];
`ifdef REGFILE_BYPASS_EN
      logic hit_link, hit_wr;
      assign hit_link           = link_en && (a == LINK_IDX);
      assign hit_wr             = wr_commit && (a == wr_addr);
      assign rd_data[i*W +: W]  = hit_link ? link_val : (hit_wr ? wr_data : stored);
      assign rd_busy[i]         = busy_raw[i] && !hit_link && !hit_wr;
`else
      assign rd_data[i*W +: W]  = stored;
      assign rd_busy[i]         = busy_raw[i];
`endif
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an array/scoreboard reference model. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int NRD = 2;
   localparam int AW  = 5;
   localparam int W   = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NRD*AW-1:0] rd_addr = '0;
   logic [NRD*W-1:0]  rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [W-1:0]      wr_data = '0;
   logic              link_en = 1'b0;
   logic [W-1:0]      link_pc = '0;
   logic              iss_en = 1'b0;
   logic [AW-1:0]     iss_addr = '0;
   logic [7:0]        collide_cnt;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .link_en     (link_en),
      .link_pc     (link_pc),
      .iss_en      (iss_en),
      .iss_addr    (iss_addr),
      .collide_cnt (collide_cnt)
   );

   // Reference model: plain register array, pending flags, collision count
   logic [W-1:0] m_mem [32];
   bit           m_pend [32];
   int           m_cnt;
   int           checks = 0;
   int           errors = 0;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_cnt = 0;
   endfunction

   function automatic void model_commit();
      if (wr_en && link_en && wr_addr == 5'd31) begin
         if (m_cnt < 255) m_cnt++;
      end else if (wr_en && wr_addr != 5'd0) begin
         m_mem[wr_addr]  = wr_data;
         m_pend[wr_addr] = 1'b0;
      end
      if (link_en) begin
         m_mem[31]  = link_pc + 32'd4;
         m_pend[31] = 1'b0;
      end
      if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
   endfunction

   function automatic logic [W-1:0] exp_rd(input int a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (link_en && a == 31) return link_pc + 32'd4;
      if (wr_en && a == int'(wr_addr)) return wr_data;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if ((link_en && a == 31) || (wr_en && a == int'(wr_addr))) return 1'b0;
`endif
      return m_pend[a];
   endfunction

   function automatic void set_rd(input int a0, input int a1);
      rd_addr = {5'(a1), 5'(a0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) model_commit();
      wr_en   = 1'b0;
      link_en = 1'b0;
      iss_en  = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      checks++;
      if (collide_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d want 0", collide_cnt);
      end
      for (int a = 0; a < 32; a++) begin
         set_rd(a, 31 - a);
         #1;
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== 32'd0 || rd_busy[p] !== 1'b0) begin
               errors++;
               $display("FAIL reset_read port%0d addr%0d got %h/%b want 0/0", p,
                        rd_addr[p*AW +: AW], rd_data[p*W +: W], rd_busy[p]);
            end
         end
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hdeadbeef;
      tick();
      set_rd(5, 5);
      #1;
      for (int p = 0; p < NRD; p++) begin
         checks++;
         if (rd_data[p*W +: W] !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL write_r5 port%0d got %h want deadbeef", p, rd_data[p*W +: W]);
         end
      end
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      tick();
      set_rd(0, 5);
      #1;
      checks++;
      if (rd_data[0 +: W] !== 32'd0 || rd_data[W +: W] !== 32'hdeadbeef) begin
         errors++;
         $display("FAIL write_r0 got %h/%h want 0/deadbeef", rd_data[0 +: W], rd_data[W +: W]);
      end
   endtask

   task automatic test_link();
      link_en = 1'b1; link_pc = 32'h0040_0010;
      tick();
      set_rd(31, 0);
      #1;
      checks++;
      if (rd_data[0 +: W] !== 32'h0040_0014) begin
         errors++;
         $display("FAIL link_basic got %h want 00400014", rd_data[0 +: W]);
      end
      link_en = 1'b1; link_pc = 32'hffff_fffe;
      tick();
      #1;
      checks++;
      if (rd_data[0 +: W] !== 32'h0000_0002) begin
         errors++;
         $display("FAIL link_wrap got %h want 00000002", rd_data[0 +: W]);
      end
   endtask

   task automatic test_collide();
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'haaaa; link_en = 1'b1; link_pc = 32'h100;
      tick();
      set_rd(31, 31);
      #1;
      checks++;
      if (rd_data[0 +: W] !== 32'h104 || collide_cnt !== 8'd1) begin
         errors++;
         $display("FAIL collide_one got %h cnt %0d want 104 cnt 1", rd_data[0 +: W], collide_cnt);
      end
      for (int i = 0; i < 300; i++) begin
         wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'haaaa; link_en = 1'b1; link_pc = 32'h100;
         tick();
      end
      #1;
      checks++;
      if (collide_cnt !== 8'd255 || rd_data[W +: W] !== 32'h104) begin
         errors++;
         $display("FAIL collide_sat cnt %0d r31 %h want 255 104", collide_cnt, rd_data[W +: W]);
      end
   endtask

   task automatic test_scoreboard();
      iss_en = 1'b1; iss_addr = 5'd7;
      tick();
      set_rd(7, 0);
      #1;
      checks++;
      if (rd_busy !== 2'b01) begin
         errors++;
         $display("FAIL sb_set got %b want 01", rd_busy);
      end
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
      tick();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[0 +: W] !== 32'h77) begin
         errors++;
         $display("FAIL sb_clear got %b/%h want 0/77", rd_busy[0], rd_data[0 +: W]);
      end
      iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
      tick();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_set_wins got %b want 1", rd_busy[0]);
      end
      iss_en = 1'b1; iss_addr = 5'd31; link_en = 1'b1; link_pc = 32'h300;
      tick();
      set_rd(31, 0);
      #1;
      checks++;
      if (rd_busy !== 2'b01 || rd_data[0 +: W] !== 32'h304) begin
         errors++;
         $display("FAIL sb_link_reset got %b/%h want 01/304", rd_busy, rd_data[0 +: W]);
      end
      iss_en = 1'b1; iss_addr = 5'd0;
      tick();
      #1;
      checks++;
      if (rd_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL sb_r0 got %b want 0", rd_busy[1]);
      end
   endtask

   task automatic test_bypass();
      logic [W-1:0] want;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
      tick();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      set_rd(9, 31);
      link_en = 1'b1; link_pc = 32'h200;
      #1;
`ifdef REGFILE_BYPASS_EN
      want = 32'h55;
`else
      want = 32'h11;
`endif
      checks++;
      if (rd_data[0 +: W] !== want) begin
         errors++;
         $display("FAIL bypass_same_cycle got %h want %h", rd_data[0 +: W], want);
      end
      checks++;
      if (rd_data[W +: W] !== exp_rd(31) || rd_busy[1] !== exp_busy(31)) begin
         errors++;
         $display("FAIL bypass_link got %h/%b want %h/%b", rd_data[W +: W], rd_busy[1],
                  exp_rd(31), exp_busy(31));
      end
      tick();
      #1;
      checks++;
      if (rd_data[0 +: W] !== 32'h55) begin
         errors++;
         $display("FAIL bypass_next_cycle got %h want 55", rd_data[0 +: W]);
      end
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hcafe;
      tick();
      wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66; iss_en = 1'b1; iss_addr = 5'd6;
      set_rd(3, 7);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00 || collide_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_async got %h/%b cnt %0d want 0", rd_data, rd_busy, collide_cnt);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      wr_en = 1'b0; iss_en = 1'b0;
      set_rd(6, 3);
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
         errors++;
         $display("FAIL reset_deassert_write got %h/%b want 0/00", rd_data, rd_busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         wr_en    = 1'($urandom_range(1));
         wr_addr  = ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(31));
         wr_data  = $urandom;
         link_en  = ($urandom_range(3) == 0);
         link_pc  = $urandom;
         iss_en   = 1'($urandom_range(1));
         iss_addr = 5'($urandom_range(31));
         set_rd(int'($urandom_range(31)), int'($urandom_range(31)));
         #1;
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== exp_rd(int'(rd_addr[p*AW +: AW])) ||
                rd_busy[p] !== exp_busy(int'(rd_addr[p*AW +: AW]))) begin
               errors++;
               $display("FAIL random_read it%0d port%0d addr%0d got %h/%b want %h/%b", i, p,
                        rd_addr[p*AW +: AW], rd_data[p*W +: W], rd_busy[p],
                        exp_rd(int'(rd_addr[p*AW +: AW])), exp_busy(int'(rd_addr[p*AW +: AW])));
            end
         end
         checks++;
         if (int'(collide_cnt) != m_cnt) begin
            errors++;
            $display("FAIL random_cnt it%0d got %0d want %0d", i, collide_cnt, m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_link();
      test_collide();
      test_scoreboard();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
